// File: rtl/post_fft_pkg.sv
// Shared definitions for the post-FFT ping-pong scheduler: bank-state encoding and sizing constants.
package post_fft_pkg;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int BYTES_PER_SAMPLE  = 4;
  localparam int DEFAULT_FRAME_LEN = 2048;

endpackage

// File: rtl/post_fft_bank_tracker.sv
// Ownership tracker for the two BRAM banks: per-bank FREE/FILLING/FULL state plus write and read pointers.
module post_fft_bank_tracker
  import post_fft_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic accept,
  input  logic frame_end,
  input  logic rd_release,
  input  logic flush,
  output logic wr_bank,
  output logic rd_bank,
  output logic wr_full,
  output logic rd_valid
);

  bank_state_e st [2];
  logic        rel_ok;

  assign wr_full  = (st[wr_bank] == BANK_FULL);
  assign rd_valid = (st[rd_bank] == BANK_FULL);
  assign rel_ok   = rd_release && rd_valid;

  // A release only ever hits a FULL bank and an accept only a non-FULL one, so
  // the branches below never compete for the same bank in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st[0]   <= BANK_FREE;
      st[1]   <= BANK_FREE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (flush && st[b] == BANK_FILLING)
          st[b] <= BANK_FREE;
        else if (accept && wr_bank == 1'(b))
          st[b] <= frame_end ? BANK_FULL : BANK_FILLING;
        else if (rel_ok && rd_bank == 1'(b))
          st[b] <= BANK_FREE;
      end
      if (frame_end) wr_bank <= ~wr_bank;
      if (rel_ok)    rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: rtl/post_fft_pingpong_scheduler.sv
// Writes FFT output frames into a two-bank BRAM region and hands full banks to a downstream reader.
// Define POST_FFT_TLAST_CHECK_EN to add the sticky frame_err output (tlast vs. sample counter).
module post_fft_pingpong_scheduler
  import post_fft_pkg::*;
#(
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BANK1_BASE = FRAME_LEN * BYTES_PER_SAMPLE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] fft_m_axis_data_tdata,
  input  logic              fft_m_axis_data_tvalid,
  input  logic              fft_m_axis_data_tlast,
  output logic              fft_m_axis_data_tready,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [3:0]        wea,
  output logic              ena,
  output logic              rd_bank_valid,
  output logic              rd_bank_sel,
  output logic [ADDR_W-1:0] rd_bank_base,
  input  logic              rd_bank_release,
  input  logic              flush,
  output logic [15:0]       frame_count,
  output logic              overflow_stall
`ifdef POST_FFT_TLAST_CHECK_EN
  ,
  output logic              frame_err
`endif
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic             alive;
  logic             wr_bank, rd_bank, wr_full;
  logic [IDX_W-1:0] wr_idx;
  logic             last_idx, accept, frame_end;
  logic [ADDR_W-1:0] wr_base;
  wr_req_t          wr_req;

  // alive holds tready/overflow low until the first clock after reset release.
  assign fft_m_axis_data_tready = alive && !wr_full && !flush;
  assign overflow_stall         = alive && fft_m_axis_data_tvalid && wr_full;
  assign accept    = fft_m_axis_data_tvalid && fft_m_axis_data_tready;
  assign last_idx  = (wr_idx == IDX_W'(FRAME_LEN - 1));
  assign frame_end = accept && last_idx;

  assign wr_base      = wr_bank ? ADDR_W'(BANK1_BASE) : '0;
  assign rd_bank_sel  = rd_bank;
  assign rd_bank_base = rd_bank ? ADDR_W'(BANK1_BASE) : '0;
  assign wr_req = '{addr: wr_base + ADDR_W'(wr_idx) * ADDR_W'(BYTES_PER_SAMPLE),
                    data: fft_m_axis_data_tdata};

  post_fft_bank_tracker u_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .accept    (accept),
    .frame_end (frame_end),
    .rd_release(rd_bank_release),
    .flush     (flush),
    .wr_bank   (wr_bank),
    .rd_bank   (rd_bank),
    .wr_full   (wr_full),
    .rd_valid  (rd_bank_valid)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alive       <= 1'b0;
      ena         <= 1'b0;
      wea         <= 4'b0000;
      addra       <= '0;
      dina        <= '0;
      wr_idx      <= '0;
      frame_count <= '0;
    end else begin
      alive <= 1'b1;
      ena   <= 1'b1;
      wea   <= accept ? 4'b1111 : 4'b0000;
      if (accept) begin
        addra <= wr_req.addr;
        dina  <= wr_req.data;
      end
      // wr_idx is exactly log2(FRAME_LEN) wide, so the increment wraps at frame end.
      if (flush)       wr_idx <= '0;
      else if (accept) wr_idx <= wr_idx + 1'b1;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef POST_FFT_TLAST_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      frame_err <= 1'b0;
    else if (flush)
      frame_err <= 1'b0;
    else if (accept && (fft_m_axis_data_tlast != last_idx))
      frame_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = fft_m_axis_data_tlast;
`endif

endmodule

// File: tb/tb_post_fft_pingpong_scheduler.sv
// Bench for post_fft_pingpong_scheduler: directed vector table, then randomized traffic against a frame-count model.
module tb_post_fft_pingpong_scheduler;

  localparam int FL = 8;
  localparam int B1 = FL * 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, tready;
  logic [31:0] addra, dina, rd_bank_base;
  logic [3:0]  wea;
  logic        ena, rd_bank_valid, rd_bank_sel;
  logic        rel = 1'b0, flush = 1'b0, overflow_stall;
  logic [15:0] frame_count;
`ifdef POST_FFT_TLAST_CHECK_EN
  logic        frame_err;
`endif

  always #5 clk = ~clk;

  post_fft_pingpong_scheduler #(.FRAME_LEN(FL), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .fft_m_axis_data_tdata(tdata), .fft_m_axis_data_tvalid(tvalid),
    .fft_m_axis_data_tlast(tlast), .fft_m_axis_data_tready(tready),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .rd_bank_valid(rd_bank_valid), .rd_bank_sel(rd_bank_sel), .rd_bank_base(rd_bank_base),
    .rd_bank_release(rel), .flush(flush),
    .frame_count(frame_count), .overflow_stall(overflow_stall)
`ifdef POST_FFT_TLAST_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: frames completed, frames released, sample position, tlast error.
  int   m_done = 0, m_rel = 0, m_idx = 0;
  logic m_err = 1'b0;

  task automatic model_step(input logic tv, input logic tl, input logic rl, input logic fl,
                            output logic acc, output logic [31:0] addr);
    int full;
    full = m_done - m_rel;
    acc  = tv && (full < 2) && !fl;
    addr = 32'((m_done % 2) * B1 + 4 * m_idx);
    if (fl) begin m_idx = 0; m_err = 1'b0; end
    if (acc) begin
      if (tl != (m_idx == FL - 1)) m_err = 1'b1;
      m_idx++;
      if (m_idx == FL) begin m_idx = 0; m_done++; end
    end
    if (rl && full > 0) m_rel++;
  endtask

  task automatic cycle(input logic tv, input logic [31:0] td, input logic tl, input logic rl,
                       input logic fl, output logic o_trdy, output logic o_ovf, output logic o_rdv,
                       output logic o_sel, output logic [31:0] o_base);
    @(negedge clk);
    tvalid = tv; tdata = td; tlast = tl; rel = rl; flush = fl;
    #1;
    o_trdy = tready; o_ovf = overflow_stall; o_rdv = rd_bank_valid;
    o_sel = rd_bank_sel; o_base = rd_bank_base;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic tv; logic [31:0] td; logic tl, rl, fl;
    logic e_trdy, e_ovf, e_wea; logic [31:0] e_addr; logic [15:0] e_fc; logic e_rdv, e_sel;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic tv, input logic [31:0] td, input logic tl, input logic rl,
                     input logic fl, input logic e_trdy, input logic e_ovf, input logic e_wea,
                     input logic [31:0] e_addr, input logic [15:0] e_fc, input logic e_rdv,
                     input logic e_sel);
    vec_t v;
    v.tv = tv; v.td = td; v.tl = tl; v.rl = rl; v.fl = fl;
    v.e_trdy = e_trdy; v.e_ovf = e_ovf; v.e_wea = e_wea; v.e_addr = e_addr;
    v.e_fc = e_fc; v.e_rdv = e_rdv; v.e_sel = e_sel;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c_trdy, c_ovf, c_rdv, c_sel, acc;
    logic [31:0] c_base, e_addr;

    // Frame 1 into bank 0, frame 2 into bank 1, stall with both full.
    for (int i = 0; i < FL; i++)
      add(1, 32'h100 + i, i == FL-1, 0, 0, 1, 0, 1, 4*i, (i == FL-1) ? 16'd1 : 16'd0, i == FL-1, 0);
    for (int i = 0; i < FL; i++)
      add(1, 32'h108 + i, i == FL-1, 0, 0, 1, 0, 1, B1 + 4*i, (i == FL-1) ? 16'd2 : 16'd1, 1, 0);
    for (int i = 0; i < 3; i++)
      add(1, 32'hDEAD, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0);
    // Release bank 0 from both-full, refill it while releasing bank 1 on its final sample.
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 1);
    for (int i = 0; i < FL; i++)
      add(1, 32'h200 + i, i == FL-1, i == FL-1, 0, 1, 0, 1, 4*i,
          (i == FL-1) ? 16'd3 : 16'd2, 1, (i == FL-1) ? 1'b0 : 1'b1);
    // Final accept of bank 1 coincides with release of bank 0.
    for (int i = 0; i < FL; i++)
      add(1, 32'h300 + i, i == FL-1, i == FL-1, 0, 1, 0, 1, B1 + 4*i,
          (i == FL-1) ? 16'd4 : 16'd3, 1, (i == FL-1) ? 1'b1 : 1'b0);
    // Partial frame then flush; next sample lands at the bank base.
    for (int i = 0; i < 3; i++)
      add(1, 32'h400 + i, 0, 0, 0, 1, 0, 1, 4*i, 4, 1, 1);
    add(1, 32'h4FF, 0, 0, 1, 0, 0, 0, 0, 4, 1, 1);
    add(1, 32'h500, 0, 0, 0, 1, 0, 1, 0, 4, 1, 1);

    tvalid = 1'b1;
    #23;
    chk("rst_tready", tready, 0);      chk("rst_ena", ena, 0);
    chk("rst_wea", wea, 0);            chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);          chk("rst_rd_valid", rd_bank_valid, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_overflow", overflow_stall, 0);
    chk("rst_rd_sel", rd_bank_sel, 0);
    tvalid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ena", ena, 1);
    chk("post_rst_tready", tready, 1);

    foreach (tbl[k]) begin
      model_step(tbl[k].tv, tbl[k].tl, tbl[k].rl, tbl[k].fl, acc, e_addr);
      cycle(tbl[k].tv, tbl[k].td, tbl[k].tl, tbl[k].rl, tbl[k].fl, c_trdy, c_ovf, c_rdv, c_sel, c_base);
      chk($sformatf("tbl%0d_tready", k), c_trdy, tbl[k].e_trdy);
      chk($sformatf("tbl%0d_overflow", k), c_ovf, tbl[k].e_ovf);
      chk($sformatf("tbl%0d_wea", k), wea, {4{tbl[k].e_wea}});
      if (tbl[k].e_wea) begin
        chk($sformatf("tbl%0d_addra", k), addra, tbl[k].e_addr);
        chk($sformatf("tbl%0d_dina", k), dina, tbl[k].td);
      end
      chk($sformatf("tbl%0d_frame_count", k), frame_count, tbl[k].e_fc);
      chk($sformatf("tbl%0d_rd_valid", k), rd_bank_valid, tbl[k].e_rdv);
      chk($sformatf("tbl%0d_rd_sel", k), rd_bank_sel, tbl[k].e_sel);
      chk($sformatf("tbl%0d_rd_base", k), rd_bank_base, tbl[k].e_sel ? B1 : 0);
    end

    for (int n = 0; n < 600; n++) begin
      logic tv, tl, rl, fl, e_trdy, e_ovf, e_rdv, e_sel;
      logic [31:0] td;
      int full;
      tv = ($urandom % 4) != 0;
      rl = ($urandom % 3) == 0;
      fl = ($urandom % 20) == 0;
      td = $urandom;
      tl = (($urandom % 10) == 0) ? 1'($urandom) : (m_idx == FL - 1);
      full   = m_done - m_rel;
      e_trdy = (full < 2) && !fl;
      e_ovf  = tv && (full == 2);
      e_rdv  = full > 0;
      e_sel  = m_rel[0];
      model_step(tv, tl, rl, fl, acc, e_addr);
      cycle(tv, td, tl, rl, fl, c_trdy, c_ovf, c_rdv, c_sel, c_base);
      chk("rnd_tready", c_trdy, e_trdy);
      chk("rnd_overflow", c_ovf, e_ovf);
      chk("rnd_rd_valid", c_rdv, e_rdv);
      chk("rnd_rd_sel", c_sel, e_sel);
      chk("rnd_rd_base", c_base, e_sel ? B1 : 0);
      chk("rnd_wea", wea, acc ? 4'hF : 4'h0);
      if (acc) begin
        chk("rnd_addra", addra, e_addr);
        chk("rnd_dina", dina, td);
      end
      chk("rnd_frame_count", frame_count, m_done[15:0]);
`ifdef POST_FFT_TLAST_CHECK_EN
      chk("rnd_frame_err", frame_err, m_err);
`endif
    end

`ifdef POST_FFT_TLAST_CHECK_EN
    // Drain both banks, flush, then tlast on sample 5 of a fresh frame.
    model_step(0, 0, 0, 1, acc, e_addr);
    cycle(0, 0, 0, 0, 1, c_trdy, c_ovf, c_rdv, c_sel, c_base);
    chk("ferr_flush_clear", frame_err, 0);
    for (int i = 0; i < 4; i++) begin
      model_step(0, 0, 1, 0, acc, e_addr);
      cycle(0, 0, 0, 1, 0, c_trdy, c_ovf, c_rdv, c_sel, c_base);
    end
    for (int i = 0; i < FL; i++) begin
      model_step(1, i == 5, 0, 0, acc, e_addr);
      cycle(1, 32'h600 + i, i == 5, 0, 0, c_trdy, c_ovf, c_rdv, c_sel, c_base);
      chk("ferr_accept", wea, 4'hF);
      chk("ferr_value", frame_err, (i >= 5) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      model_step(0, 0, 0, 0, acc, e_addr);
      cycle(0, 0, 0, 0, 0, c_trdy, c_ovf, c_rdv, c_sel, c_base);
      chk("ferr_sticky", frame_err, 1);
    end
    model_step(0, 0, 0, 1, acc, e_addr);
    cycle(0, 0, 0, 0, 1, c_trdy, c_ovf, c_rdv, c_sel, c_base);
    chk("ferr_cleared", frame_err, 0);
`endif

    @(negedge clk);
    tvalid = 1'b0; rel = 1'b0; flush = 1'b0; tlast = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
